// File: rtl/bin_to_bcd_stream_if.sv
// rtl/bin_to_bcd_stream_if.sv - handshake bundle for the binary-to-BCD stream converter
// master drives the conversion request and result acceptance; slave is the converter.
interface bin_to_bcd_stream_if #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [BIN_W-1:0]      bin_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  sign_out;
   logic                  ovf;
   logic [DIGITS-1:0]     lz_mask;

   modport master (
      output in_valid, bin_in, out_ready,
      input  in_ready, out_valid, bcd_out, sign_out, ovf, lz_mask
   );

   modport slave (
      input  in_valid, bin_in, out_ready,
      output in_ready, out_valid, bcd_out, sign_out, ovf, lz_mask
   );
endinterface

// File: rtl/bin_to_bcd_stream.sv
// rtl/bin_to_bcd_stream.sv - sequential double-dabble binary-to-BCD converter
// One bit per clock; optional two's-complement input, overflow saturation, leading-zero mask.
module bin_to_bcd_stream #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5,
   parameter int SIGNED = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   bin_to_bcd_stream_if.slave   bus
);
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int ACC_W = 4 * DIGITS;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CONV = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIN_W);
   localparam logic [ACC_W-1:0]  NINES    = {DIGITS{4'h9}};
   localparam logic [DIGITS-1:0] LZ_RESET = ~(DIGITS'(1));

   logic [1:0]        r_state;
   logic [BIN_W-1:0]  r_mag;
   logic [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_sign;
   logic              r_ovf;
   logic [ACC_W-1:0]  r_bcd_out;
   logic              r_sign_out;
   logic              r_ovf_out;
   logic [DIGITS-1:0] r_lz_mask;

   logic              w_sign_in;
   logic [BIN_W-1:0]  w_mag_in;
   logic [ACC_W-1:0]  w_adj;
   logic [ACC_W-1:0]  w_acc_next;
   logic [BIN_W-1:0]  w_mag_next;
   logic [DIGITS-1:0] w_lz;
   logic              w_zero_run;

   // Negation wraps in BIN_W bits, so the most negative input becomes 2^(BIN_W-1).
   assign w_sign_in = (SIGNED != 0) && bus.bin_in[BIN_W-1];
   assign w_mag_in  = w_sign_in ? (~bus.bin_in + BIN_W'(1)) : bus.bin_in;

   always_comb begin
      w_adj = '0;
      for (int k = 0; k < DIGITS; k++) begin
         w_adj[4*k +: 4] = (r_acc[4*k +: 4] >= 4'd5) ? (r_acc[4*k +: 4] + 4'd3)
                                                      : r_acc[4*k +: 4];
      end
   end

   assign w_acc_next = {w_adj[ACC_W-2:0], r_mag[BIN_W-1]};
   assign w_mag_next = {r_mag[BIN_W-2:0], 1'b0};

   // Scan from the top digit down; a digit is blankable while everything above it is zero.
   always_comb begin
      w_zero_run = 1'b1;
      w_lz       = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         w_zero_run = w_zero_run & (r_acc[4*k +: 4] == 4'd0);
         if (k > 0) w_lz[k] = w_zero_run;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_mag      <= '0;
         r_acc      <= '0;
         r_cnt      <= '0;
         r_sign     <= 1'b0;
         r_ovf      <= 1'b0;
         r_bcd_out  <= '0;
         r_sign_out <= 1'b0;
         r_ovf_out  <= 1'b0;
         r_lz_mask  <= LZ_RESET;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_mag   <= w_mag_in;
                  r_sign  <= w_sign_in;
                  r_acc   <= '0;
                  r_ovf   <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_CONV;
               end
            end
            S_CONV: begin
               if (r_cnt == CNT_LAST) begin
                  r_bcd_out  <= r_ovf ? NINES : r_acc;
                  r_lz_mask  <= r_ovf ? '0 : w_lz;
                  r_sign_out <= r_sign;
                  r_ovf_out  <= r_ovf;
                  r_state    <= S_HOLD;
               end else begin
                  // A set top bit after adjust would be lost by the shift: value too large.
                  r_acc <= w_acc_next;
                  r_mag <= w_mag_next;
                  r_ovf <= r_ovf | w_adj[ACC_W-1];
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_HOLD: begin
               if (bus.out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_HOLD);
   assign bus.bcd_out   = r_bcd_out;
   assign bus.sign_out  = (SIGNED != 0) ? r_sign_out : 1'b0;
   assign bus.ovf       = r_ovf_out;
   assign bus.lz_mask   = r_lz_mask;
endmodule

// File: tb/tb_bin_to_bcd_stream.sv
// tb/tb_bin_to_bcd_stream.sv - self-checking bench for bin_to_bcd_stream
// Three configurations share one clock; sel routes stimulus and results through a mux.
module tb_bin_to_bcd_stream;
   typedef struct {
      int          sel;
      logic [11:0] bin;
      logic [15:0] bcd;
      logic        sign;
      logic        ovf;
      logic [3:0]  lz;
   } vec_t;

   typedef struct {
      logic [15:0] bcd;
      logic        sign;
      logic        ovf;
      logic [3:0]  lz;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          sel = 0;
   logic        tb_in_valid = 1'b0;
   logic [11:0] tb_bin = '0;
   logic        tb_out_ready = 1'b0;

   logic        m_in_ready, m_out_valid, m_sign, m_ovf;
   logic [15:0] m_bcd;
   logic [3:0]  m_lz;

   int n_checks = 0;
   int n_fail   = 0;
   exp_t exp_q[$];
   vec_t vecs[15];

   always #5 clk = ~clk;

   bin_to_bcd_stream_if #(.BIN_W(12), .DIGITS(4)) if_a ();
   bin_to_bcd_stream_if #(.BIN_W(8),  .DIGITS(3)) if_b ();
   bin_to_bcd_stream_if #(.BIN_W(12), .DIGITS(3)) if_c ();

   bin_to_bcd_stream #(.BIN_W(12), .DIGITS(4), .SIGNED(0)) u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   bin_to_bcd_stream #(.BIN_W(8),  .DIGITS(3), .SIGNED(1)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
   bin_to_bcd_stream #(.BIN_W(12), .DIGITS(3), .SIGNED(0)) u_c (.clk(clk), .rst(rst), .bus(if_c.slave));

   assign if_a.in_valid  = tb_in_valid && (sel == 0);
   assign if_b.in_valid  = tb_in_valid && (sel == 1);
   assign if_c.in_valid  = tb_in_valid && (sel == 2);
   assign if_a.bin_in    = tb_bin;
   assign if_b.bin_in    = tb_bin[7:0];
   assign if_c.bin_in    = tb_bin;
   assign if_a.out_ready = tb_out_ready && (sel == 0);
   assign if_b.out_ready = tb_out_ready && (sel == 1);
   assign if_c.out_ready = tb_out_ready && (sel == 2);

   always_comb begin
      m_in_ready  = if_c.in_ready;
      m_out_valid = if_c.out_valid;
      m_bcd       = {4'h0, if_c.bcd_out};
      m_sign      = if_c.sign_out;
      m_ovf       = if_c.ovf;
      m_lz        = {1'b0, if_c.lz_mask};
      if (sel == 0) begin
         m_in_ready  = if_a.in_ready;
         m_out_valid = if_a.out_valid;
         m_bcd       = if_a.bcd_out;
         m_sign      = if_a.sign_out;
         m_ovf       = if_a.ovf;
         m_lz        = if_a.lz_mask;
      end else if (sel == 1) begin
         m_in_ready  = if_b.in_ready;
         m_out_valid = if_b.out_valid;
         m_bcd       = {4'h0, if_b.bcd_out};
         m_sign      = if_b.sign_out;
         m_ovf       = if_b.ovf;
         m_lz        = {1'b0, if_b.lz_mask};
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic start_conv(input int s, input logic [11:0] b, input exp_t e);
      int waited = 0;
      @(negedge clk);
      sel = s;
      #1;
      while (!m_in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      check("in_ready_before_accept", {31'd0, m_in_ready}, 32'd1);
      tb_in_valid = 1'b1;
      tb_bin      = b;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      tb_in_valid = 1'b0;
      check("in_ready_after_accept", {31'd0, m_in_ready}, 32'd0);
   endtask

   task automatic wait_result(input string name, input int lat);
      int cycles = 0;
      exp_t e;
      while (!m_out_valid && cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      check({name, "_latency"}, cycles, lat);
      if (exp_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_scoreboard: got result, expected none", name);
      end else begin
         e = exp_q.pop_front();
         check({name, "_bcd"},  {16'd0, m_bcd},  {16'd0, e.bcd});
         check({name, "_sign"}, {31'd0, m_sign}, {31'd0, e.sign});
         check({name, "_ovf"},  {31'd0, m_ovf},  {31'd0, e.ovf});
         check({name, "_lz"},   {28'd0, m_lz},   {28'd0, e.lz});
      end
   endtask

   task automatic accept_result(input string name);
      @(negedge clk);
      tb_out_ready = 1'b1;
      @(posedge clk);
      #1;
      tb_out_ready = 1'b0;
      check({name, "_out_valid_drop"}, {31'd0, m_out_valid}, 32'd0);
      check({name, "_in_ready_back"},  {31'd0, m_in_ready},  32'd1);
   endtask

   function automatic exp_t mk(input logic [15:0] bcd, input logic sign, input logic ovf,
                               input logic [3:0] lz);
      exp_t e;
      e.bcd = bcd; e.sign = sign; e.ovf = ovf; e.lz = lz;
      return e;
   endfunction

   initial begin
      vecs[0]  = '{0, 12'd4095, 16'h4095, 1'b0, 1'b0, 4'b0000};
      vecs[1]  = '{0, 12'd0,    16'h0000, 1'b0, 1'b0, 4'b1110};
      vecs[2]  = '{0, 12'd7,    16'h0007, 1'b0, 1'b0, 4'b1110};
      vecs[3]  = '{0, 12'd1234, 16'h1234, 1'b0, 1'b0, 4'b0000};
      vecs[4]  = '{0, 12'd56,   16'h0056, 1'b0, 1'b0, 4'b1100};
      vecs[5]  = '{0, 12'd100,  16'h0100, 1'b0, 1'b0, 4'b1000};
      vecs[6]  = '{1, 12'h080,  16'h0128, 1'b1, 1'b0, 4'b0000};
      vecs[7]  = '{1, 12'h0FF,  16'h0001, 1'b1, 1'b0, 4'b0110};
      vecs[8]  = '{1, 12'h07F,  16'h0127, 1'b0, 1'b0, 4'b0000};
      vecs[9]  = '{1, 12'h000,  16'h0000, 1'b0, 1'b0, 4'b0110};
      vecs[10] = '{1, 12'h0F6,  16'h0010, 1'b1, 1'b0, 4'b0100};
      vecs[11] = '{2, 12'd1000, 16'h0999, 1'b0, 1'b1, 4'b0000};
      vecs[12] = '{2, 12'd999,  16'h0999, 1'b0, 1'b0, 4'b0000};
      vecs[13] = '{2, 12'd4095, 16'h0999, 1'b0, 1'b1, 4'b0000};
      vecs[14] = '{2, 12'd5,    16'h0005, 1'b0, 1'b0, 4'b0110};

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  {31'd0, m_in_ready},  32'd1);
      check("rst_out_valid", {31'd0, m_out_valid}, 32'd0);
      check("rst_bcd",       {16'd0, m_bcd},       32'd0);
      check("rst_sign",      {31'd0, m_sign},      32'd0);
      check("rst_ovf",       {31'd0, m_ovf},       32'd0);
      check("rst_lz",        {28'd0, m_lz},        32'hE);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 15; i++) begin
         start_conv(vecs[i].sel, vecs[i].bin,
                    mk(vecs[i].bcd, vecs[i].sign, vecs[i].ovf, vecs[i].lz));
         wait_result($sformatf("vec%0d", i), (vecs[i].sel == 1) ? 9 : 13);
         accept_result($sformatf("vec%0d", i));
      end

      // Backpressure: result must hold while extra in_valid pulses are ignored.
      start_conv(0, 12'd321, mk(16'h0321, 1'b0, 1'b0, 4'b1000));
      wait_result("bp", 13);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tb_in_valid = c[0];
         tb_bin      = 12'd77;
         @(posedge clk);
         #1;
         check("bp_hold_bcd",   {16'd0, m_bcd},       32'h0321);
         check("bp_hold_valid", {31'd0, m_out_valid}, 32'd1);
         check("bp_hold_ready", {31'd0, m_in_ready},  32'd0);
         check("bp_hold_lz",    {28'd0, m_lz},        32'h8);
      end
      tb_in_valid = 1'b0;
      accept_result("bp");
      repeat (3) @(posedge clk);
      #1;
      check("bp_no_spurious_start", {31'd0, m_in_ready}, 32'd1);

      // Reset in the middle of a conversion.
      start_conv(0, 12'd4095, mk(16'h4095, 1'b0, 1'b0, 4'b0000));
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      void'(exp_q.pop_front());
      check("mid_rst_in_ready",  {31'd0, m_in_ready},  32'd1);
      check("mid_rst_out_valid", {31'd0, m_out_valid}, 32'd0);
      check("mid_rst_bcd",       {16'd0, m_bcd},       32'd0);
      check("mid_rst_lz",        {28'd0, m_lz},        32'hE);
      @(negedge clk);
      rst = 1'b0;
      start_conv(0, 12'd58, mk(16'h0058, 1'b0, 1'b0, 4'b1100));
      wait_result("post_rst", 13);
      accept_result("post_rst");

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
